dmem_lsu: RTL and testbench

Load/store unit between the MEM stage and a handshaked data RAM with variable latency. It takes the MEM stage's data request (enable, write enable, address, write data, funct3). It produces byte enables and lane-replicated write data, and sign- or zero-extends load data. It stalls the single-cycle core until the RAM acknowledges the access, and flags misaligned accesses and bus timeouts.

---
 rtl/dmem_lsu_pkg.sv | 17 +
 rtl/dmem_lsu_align.sv | 59 +++++
 rtl/dmem_lsu.sv | 162 ++++++++++++++++
 tb/tb_dmem_lsu.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE,
    LSU_ERR
  } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_align.sv
module lsu_align
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              misalign_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = rdata_i[{addr_i, 3'b000} +: 8];
    lane_h     = rdata_i[{addr_i[1], 4'b0000} +: 16];
    be_o       = '0;
    wdata_o    = wdata_i;
    rdata_o    = '0;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_B: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {(DATA_W/8){wdata_i[7:0]}};
        rdata_o = {{(DATA_W-8){lane_b[7]}}, lane_b};
      end
      F3_BU: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {(DATA_W/8){wdata_i[7:0]}};
        rdata_o = {{(DATA_W-8){1'b0}}, lane_b};
      end
      F3_H: begin
        misalign_o = addr_i[0];
        be_o       = 4'b0011 << addr_i;
        wdata_o    = {(DATA_W/16){wdata_i[15:0]}};
        rdata_o    = {{(DATA_W-16){lane_h[15]}}, lane_h};
      end
      F3_HU: begin
        misalign_o = addr_i[0];
        be_o       = 4'b0011 << addr_i;
        wdata_o    = {(DATA_W/16){wdata_i[15:0]}};
        rdata_o    = {{(DATA_W-16){1'b0}}, lane_h};
      end
      F3_W: begin
        misalign_o = (addr_i != 2'b00);
        be_o       = '1;
        wdata_o    = wdata_i;
        rdata_o    = rdata_i;
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [DATA_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  input  logic [2:0]        req_funct3_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              done_o,
  output logic              misalign_o,
  output logic              bus_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ldata_q;

  logic              latch_en;
  logic              load_en;
  logic              expired;

  logic [2:0]        al_f3;
  logic [1:0]        al_addr;
  logic [3:0]        al_be;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_rdata;
  logic              al_mis;

  // One aligner serves both phases: live request fields in IDLE, latched fields afterwards.
  assign al_f3   = (state_q == LSU_IDLE) ? req_funct3_i    : f3_q;
  assign al_addr = (state_q == LSU_IDLE) ? req_addr_i[1:0] : addr_q[1:0];

  lsu_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .funct3_i  (al_f3),
    .addr_i    (al_addr),
    .wdata_i   (req_wdata_i),
    .rdata_i   (mem_rdata_i),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata),
    .misalign_o(al_mis)
  );

  assign expired = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_en   = 1'b0;
    load_en    = 1'b0;
    stall_o    = 1'b0;
    misalign_o = 1'b0;
    done_o     = 1'b0;
    bus_err_o  = 1'b0;
    mem_req_o  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        // IDLE outputs are combinational on the request, so keep them low while in reset.
        if (req_valid_i && rst) begin
          if (al_mis) begin
            misalign_o = 1'b1;
          end else begin
            stall_o  = 1'b1;
            latch_en = 1'b1;
            cnt_d    = '0;
            state_d  = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_gnt_i) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = LSU_WAIT;
        end else if (expired) begin
          state_d = LSU_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_WAIT: begin
        stall_o = 1'b1;
        if (mem_rvalid_i) begin
          load_en = !we_q;
          state_d = LSU_DONE;
        end else if (expired) begin
          state_d = LSU_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      LSU_DONE: begin
        done_o  = 1'b1;
        state_d = LSU_IDLE;
      end
      LSU_ERR: begin
        bus_err_o = 1'b1;
        state_d   = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        f3_q    <= req_funct3_i;
        be_q    <= req_we_i ? al_be : 4'b1111;
        wdata_q <= al_wdata;
      end
      if (load_en) begin
        ldata_q <= al_rdata;
      end
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = {addr_q[DATA_W-1:2], 2'b00};
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign load_data_o = ldata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  localparam int unsigned TIMEOUT = 64;
  localparam int EV_DONE = 0;
  localparam int EV_MIS  = 1;
  localparam int EV_ERR  = 2;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [2:0]  req_funct3_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        done_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  dmem_lsu #(
    .DATA_W (32),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (7)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_funct3_i(req_funct3_i),
    .stall_o     (stall_o),
    .load_data_o (load_data_o),
    .done_o      (done_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] ld;
    logic        is_load;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] last_load = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic mis,
                              input logic [3:0] be, input logic [31:0] wd, input logic [31:0] ld);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.mis = mis; v.be = be; v.wd = wd; v.ld = ld;
    return v;
  endfunction

  // Issue one access from a negedge; the RAM model grants after gnt_wait REQ cycles and
  // responds rv_wait cycles into WAIT. Returns stalled-cycle and REQ-cycle counts.
  task automatic do_access(input vec_t v, input int unsigned gnt_wait, input int unsigned rv_wait,
                           input int ev_kind, output int unsigned stalls, output int unsigned reqc);
    int unsigned cyc = 0;
    int unsigned waitc = 0;
    bit          granted = 1'b0;
    bit          finished = 1'b0;
    int          ev;
    exp_t        e;
    stalls = 0;
    reqc   = 0;
    e.kind = ev_kind; e.ld = v.ld; e.is_load = !v.we;
    sb.push_back(e);
    req_valid_i  = 1'b1;
    req_we_i     = v.we;
    req_addr_i   = v.addr;
    req_wdata_i  = v.wdata;
    req_funct3_i = v.f3;
    while (!finished && cyc < 300) begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      if (mem_req_o) begin
        if (reqc == gnt_wait) begin
          mem_gnt_i = 1'b1;
          granted   = 1'b1;
          chk("mem_we", {31'd0, mem_we_o}, {31'd0, v.we});
          chk("mem_addr", mem_addr_o, v.addr & ~32'h3);
          chk("mem_be", {28'd0, mem_be_o}, {28'd0, v.be});
          if (v.we) chk("mem_wdata", mem_wdata_o, v.wd);
        end
        reqc++;
      end else if (granted) begin
        if (waitc == rv_wait) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = v.rdata;
        end
        waitc++;
      end
      #1;
      if (stall_o) stalls++;
      if (done_o || misalign_o || bus_err_o) begin
        finished     = 1'b1;
        req_valid_i  = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        ev = done_o ? EV_DONE : (misalign_o ? EV_MIS : EV_ERR);
        if (ev == EV_ERR) chk("err_req_low", {31'd0, mem_req_o}, 32'd0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty: got event %0d expected none", ev);
        end else begin
          e = sb.pop_front();
          chk("event_kind", ev, e.kind);
          if (ev == EV_DONE) begin
            chk("load_data", load_data_o, e.is_load ? e.ld : last_load);
            if (e.is_load) last_load = e.ld;
          end
        end
      end
      cyc++;
      if (!finished) @(negedge clk);
    end
    if (!finished) begin
      n_checks++;
      $display("FAIL access_bound: got no completion after %0d cycles required one", cyc);
      req_valid_i = 1'b0;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      if (sb.size() != 0) void'(sb.pop_front());
    end
    @(negedge clk);
    #1;
    chk("pulse_clear", {27'd0, done_o, misalign_o, bus_err_o, mem_req_o, stall_o}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected one");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned st, rq, gw, rw;
    vec_t        v;

    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'hF, 32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 4'hF, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 4'hF, 32'h0,        32'h00000080));
    vecs.push_back(mk(0, 3'b101, 32'h102, 32'h0,        32'h80FF0000, 0, 4'hF, 32'h0,        32'h000080FF));
    vecs.push_back(mk(1, 3'b000, 32'h002, 32'h000000AB, 32'h0,        0, 4'h4, 32'hABABABAB, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h102, 32'h0,        32'h80FF0000, 0, 4'hF, 32'h0,        32'hFFFF80FF));
    vecs.push_back(mk(0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 3'b000, 32'h101, 32'h0,        32'h12345678, 0, 4'hF, 32'h0,        32'h00000056));
    vecs.push_back(mk(1, 3'b001, 32'h006, 32'h1234CAFE, 32'h0,        0, 4'hC, 32'hCAFECAFE, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h100, 32'h0,        32'h1234F00D, 0, 4'hF, 32'h0,        32'hFFFFF00D));
    vecs.push_back(mk(0, 3'b001, 32'h101, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 3'b010, 32'h008, 32'h01234567, 32'h0,        0, 4'hF, 32'h01234567, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h007, 32'hFFFFFF5A, 32'h0,        0, 4'h8, 32'h5A5A5A5A, 32'h0));
    vecs.push_back(mk(1, 3'b010, 32'h003, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(1, 3'b011, 32'h000, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 3'b101, 32'h101, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 3'b110, 32'h010, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 3'b101, 32'h100, 32'h0,        32'h7FFF8001, 0, 4'hF, 32'h0,        32'h00008001));
    vecs.push_back(mk(1, 3'b001, 32'h003, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0));
    vecs.push_back(mk(0, 3'b000, 32'h100, 32'h0,        32'h0000007F, 0, 4'hF, 32'h0,        32'h0000007F));

    rst          = 1'b0;
    req_valid_i  = 1'b0;
    req_we_i     = 1'b0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    req_funct3_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctrl", {26'd0, stall_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o}, 32'd0);
    chk("rst_load_data", load_data_o, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      gw = i % 3;
      rw = (i / 3) % 2;
      do_access(vecs[i], gw, rw, vecs[i].mis ? EV_MIS : EV_DONE, st, rq);
      chk($sformatf("stalls_v%0d", i), st, vecs[i].mis ? 32'd0 : 3 + gw + rw);
      if (vecs[i].mis) chk($sformatf("no_req_v%0d", i), rq, 32'd0);
    end

    // grant withheld: bus error after TIMEOUT cycles in REQ
    v = mk(0, 3'b010, 32'h40, 32'h0, 32'h0, 0, 4'hF, 32'h0, 32'h0);
    do_access(v, 1000, 0, EV_ERR, st, rq);
    chk("to_req_stalls", st, TIMEOUT + 1);
    chk("to_req_cycles", rq, TIMEOUT);

    // response withheld: counter spans REQ and WAIT
    do_access(v, 0, 1000, EV_ERR, st, rq);
    chk("to_wait_stalls", st, TIMEOUT + 1);

    // grant on the expiry cycle wins
    v = mk(0, 3'b010, 32'h44, 32'h0, 32'h0BADF00D, 0, 4'hF, 32'h0, 32'h0BADF00D);
    do_access(v, TIMEOUT - 1, 0, EV_DONE, st, rq);
    chk("gnt_at_expiry_stalls", st, TIMEOUT + 2);
    chk("gnt_at_expiry_reqc", rq, TIMEOUT);

    // response on the expiry cycle wins
    v = mk(0, 3'b100, 32'h45, 32'h0, 32'h0000A500, 0, 4'hF, 32'h0, 32'h000000A5);
    do_access(v, 0, TIMEOUT - 2, EV_DONE, st, rq);
    chk("rv_at_expiry_stalls", st, TIMEOUT + 1);

    // reset asserted in WAIT, late response afterwards
    req_valid_i  = 1'b1;
    req_we_i     = 1'b0;
    req_addr_i   = 32'h100;
    req_funct3_i = 3'b010;
    @(negedge clk);
    #1;
    chk("rstw_in_req", {31'd0, mem_req_o}, 32'd1);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    #1;
    chk("rstw_in_wait", {30'd0, stall_o, mem_req_o}, 32'd2);
    rst = 1'b0;
    req_valid_i = 1'b0;
    #1;
    chk("rstw_ctrl", {26'd0, stall_o, done_o, misalign_o, bus_err_o, mem_req_o, mem_we_o}, 32'd0);
    chk("rstw_load_data", load_data_o, 32'd0);
    chk("rstw_mem_be", {28'd0, mem_be_o}, 32'd0);
    chk("rstw_mem_addr", mem_addr_o, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'hFFFFFFFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("late_rvalid_%0d", k), {28'd0, done_o, stall_o, mem_req_o, bus_err_o}, 32'd0);
      chk($sformatf("late_rvalid_data_%0d", k), load_data_o, 32'd0);
      @(negedge clk);
      mem_rvalid_i = 1'b0;
    end
    last_load = '0;

    // recovery after mid-access reset
    v = mk(0, 3'b010, 32'h200, 32'h0, 32'h13579BDF, 0, 4'hF, 32'h0, 32'h13579BDF);
    do_access(v, 1, 2, EV_DONE, st, rq);
    chk("recover_stalls", st, 32'd6);

    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
